// File: rtl/uart_pkg.sv
// Shared UART TX types and defaults. The PARITY state exists only when
// TX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side bundle between a combinational-read FIFO (master) and the
// UART transmitter that drains it (slave).
interface uart_tx_fifo_drain_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] r_data;
   logic                  rempty;
   logic                  rinc;

   modport master (output r_data, output rempty, input  rinc);
   modport slave  (input  r_data, input  rempty, output rinc);
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity bit over a data word: even parity when par_typ_i=0, odd when 1.
module uart_tx_parity_calc
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic                  par_typ_i,
   output logic                  par_o
);
   assign par_o = (^word_i) ^ par_typ_i;
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a combinational-read FIFO, one bit per TX_CLK.
// Define TX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
   input  logic                  TX_CLK,
   input  logic                  TX_RST,
   input  logic [DATA_WIDTH-1:0] r_data,
   input  logic                  rempty,
   output logic                  rinc,
`ifdef TX_PARITY_EN
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
`endif
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   tx_state_e             state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CW-1:0]         cnt_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  load;

`ifdef TX_PARITY_EN
   logic par_en_q;
   logic par_typ_q;
   logic par_bit;

   uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
      .word_i    (shift_q),
      .par_typ_i (par_typ_q),
      .par_o     (par_bit)
   );
`endif

   // A word is taken in IDLE or STOP; reset masks the pop strobe.
   assign load   = !rempty && ((state_q == IDLE) || (state_q == STOP));
   assign rinc   = load && !TX_RST;
   assign TX_OUT = tx_q;
   assign busy   = busy_q;

   always_ff @(posedge TX_CLK or posedge TX_RST) begin
      if (TX_RST) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
`endif
      end else if (load) begin
         state_q   <= START;
         shift_q   <= r_data;
         cnt_q     <= '0;
         tx_q      <= 1'b0;
         busy_q    <= 1'b1;
`ifdef TX_PARITY_EN
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            START: begin
               state_q <= DATA;
               tx_q    <= shift_q[0];
            end
            DATA: begin
               if (cnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                  if (par_en_q) begin
                     state_q <= PARITY;
                     tx_q    <= par_bit;
                  end else begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end
`else
                  state_q <= STOP;
                  tx_q    <= 1'b1;
`endif
               end else begin
                  // The word stays intact so parity can be taken over it.
                  cnt_q <= cnt_q + 1'b1;
                  tx_q  <= shift_q[cnt_q + 1'b1];
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               state_q <= STOP;
               tx_q    <= 1'b1;
            end
`endif
            STOP: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a small pointer-based FIFO model;
// parity vectors run only when TX_PARITY_EN is defined.
module tb_uart_tx_fifo_drain;
   import uart_pkg::*;

   logic TX_CLK = 1'b0;
   logic TX_RST = 1'b1;
   logic TX_OUT;
   logic busy;
`ifdef TX_PARITY_EN
   logic PAR_EN  = 1'b0;
   logic PAR_TYP = 1'b0;
`endif

   uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) fifo_if ();

   uart_tx_fifo_drain #(.DATA_WIDTH(8)) dut (
      .TX_CLK  (TX_CLK),
      .TX_RST  (TX_RST),
      .r_data  (fifo_if.r_data),
      .rempty  (fifo_if.rempty),
      .rinc    (fifo_if.rinc),
`ifdef TX_PARITY_EN
      .PAR_EN  (PAR_EN),
      .PAR_TYP (PAR_TYP),
`endif
      .TX_OUT  (TX_OUT),
      .busy    (busy)
   );

   always #5 TX_CLK = ~TX_CLK;

   logic [7:0]  mem [0:15];
   logic [3:0]  wr_ptr = '0;
   logic [3:0]  rd_ptr = '0;
   logic        hold_empty = 1'b0;
   int unsigned pops = 0;
   int unsigned viol = 0;

   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   assign fifo_if.r_data = mem[rd_ptr];
   assign fifo_if.rempty = (wr_ptr == rd_ptr) || hold_empty;

   always @(posedge TX_CLK) begin
      if (fifo_if.rinc) begin
         rd_ptr <= rd_ptr + 1'b1;
         pops   <= pops + 1;
      end
      if (fifo_if.rinc && fifo_if.rempty) viol <= viol + 1;
   end

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 1'b1;
   endtask

   task automatic capture(input int unsigned n, output logic [31:0] bits, output logic [31:0] bz);
      bits = '0;
      bz   = '0;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge TX_CLK);
         bits[i] = TX_OUT;
         bz[i]   = busy;
      end
   endtask

   // Cycle-indexed line image: start, data LSB first, optional parity, stop.
   function automatic logic [31:0] frame_bits(input logic [7:0] w, input logic pen, input logic ptyp);
      logic [31:0] f;
      int unsigned n;
      f = '0;
      n = 1;
      for (int i = 0; i < 8; i++) begin
         f[n] = w[i];
         n++;
      end
      if (pen) begin
         f[n] = (^w) ^ ptyp;
         n++;
      end
      f[n] = 1'b1;
      return f;
   endfunction

   task automatic idle_run(input int unsigned n, input string tag);
      int unsigned lo_tx, hi_busy, hi_rinc;
      lo_tx = 0; hi_busy = 0; hi_rinc = 0;
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge TX_CLK);
         if (TX_OUT !== 1'b1) lo_tx++;
         if (busy !== 1'b0) hi_busy++;
         if (fifo_if.rinc !== 1'b0) hi_rinc++;
      end
      check({tag, "_tx_low"}, lo_tx, 0);
      check({tag, "_busy_high"}, hi_busy, 0);
      check({tag, "_rinc_high"}, hi_rinc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] b1, z1, b2, z2;
      int unsigned p0;

      @(negedge TX_CLK);
      @(negedge TX_CLK);
      check("rst_tx", TX_OUT, 1);
      check("rst_busy", busy, 0);
      check("rst_rinc", fifo_if.rinc, 0);
      TX_RST = 1'b0;
      idle_run(20, "idle");

      p0 = pops;
      push(8'hA5);
      capture(10, b1, z1);
      check("a5_frame", b1, 32'h34A);
      check("a5_busy", z1, 32'h3FF);
      check("a5_pops", pops - p0, 1);
      @(negedge TX_CLK);
      check("a5_idle_tx", TX_OUT, 1);
      check("a5_idle_busy", busy, 0);

`ifdef TX_PARITY_EN
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      p0 = pops;
      push(8'hA5);
      capture(11, b1, z1);
      check("par_even_frame", b1, 32'h54A);
      check("par_even_busy", z1, 32'h7FF);
      PAR_TYP = 1'b1;
      push(8'hA5);
      capture(11, b1, z1);
      check("par_odd_frame", b1, 32'h74A);
      check("par_pops", pops - p0, 2);
      PAR_TYP = 1'b0;
      push(8'hA5);
      capture(3, b1, z1);
      PAR_TYP = 1'b1;
      PAR_EN = 1'b0;
      capture(8, b2, z2);
      check("par_typ_hold", b1 | (b2 << 3), 32'h54A);
      PAR_TYP = 1'b0;
      @(negedge TX_CLK);
      check("par_idle_busy", busy, 0);
`endif

      p0 = pops;
      push(8'h00);
      push(8'hFF);
      capture(20, b1, z1);
      check("b2b_frame", b1, 32'hFFA00);
      check("b2b_model", b1, frame_bits(8'h00, 1'b0, 1'b0) | (frame_bits(8'hFF, 1'b0, 1'b0) << 10));
      check("b2b_busy", z1, 32'hFFFFF);
      check("b2b_pops", pops - p0, 2);
      @(negedge TX_CLK);
      check("b2b_idle_busy", busy, 0);

      p0 = pops;
      push(8'h35);
      capture(4, b1, z1);
      check("mid_first_bits", b1[3:0], 4'b1010);
      @(posedge TX_CLK);
      #1;
      check("mid_bit3", TX_OUT, 0);
      #1 TX_RST = 1'b1;
      #1;
      check("mid_rst_tx", TX_OUT, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rinc", fifo_if.rinc, 0);
      @(negedge TX_CLK);
      @(negedge TX_CLK);
      TX_RST = 1'b0;
      idle_run(12, "post_rst");
      check("mid_no_reread", pops - p0, 1);

      @(negedge TX_CLK);
      TX_RST = 1'b1;
      p0 = pops;
      push(8'h81);
      #1;
      check("rst_gate_rinc", fifo_if.rinc, 0);
      @(negedge TX_CLK);
      @(negedge TX_CLK);
      check("rst_gate_pops", pops - p0, 0);
      TX_RST = 1'b0;
      capture(10, b1, z1);
      check("resume_frame", b1, frame_bits(8'h81, 1'b0, 1'b0));
      check("resume_pops", pops - p0, 1);

      @(negedge TX_CLK);
      p0 = pops;
      push(8'h5A);
      capture(2, b1, z1);
      push(8'h12);
      capture(7, b2, z2);
      @(negedge TX_CLK);
      b1 = b1 | (b2 << 2);
      b1[9] = TX_OUT;
      hold_empty = 1'b1;
      check("edge_frame", b1, frame_bits(8'h5A, 1'b0, 1'b0));
      @(negedge TX_CLK);
      check("edge_idle_tx", TX_OUT, 1);
      check("edge_idle_busy", busy, 0);
      check("edge_pops", pops - p0, 1);
      hold_empty = 1'b0;
      capture(10, b1, z1);
      check("edge_next_frame", b1, frame_bits(8'h12, 1'b0, 1'b0));
      check("edge_next_pops", pops - p0, 2);
      @(negedge TX_CLK);
      check("rinc_while_empty", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
